// File: rtl/dp_ram_fifo_ctrl_if.sv
// Producer/consumer handshake and status bundle for the dual-port RAM FIFO controller.
// The master side is the producer/consumer; the slave side is the controller.
interface dp_ram_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  wr_valid_in;
    logic [DATA_WIDTH-1:0] wr_data_in;
    logic                  wr_ready_out;
    logic                  rd_req_in;
    logic [DATA_WIDTH-1:0] rd_data_out;
    logic                  rd_valid_out;
    logic                  full_out;
    logic                  empty_out;
    logic                  almost_full_out;
    logic [ADDR_WIDTH:0]   count_out;
    logic                  ovf_err_out;
    logic                  udf_err_out;

    modport master (
        output wr_valid_in, wr_data_in, rd_req_in,
        input  wr_ready_out, rd_data_out, rd_valid_out, full_out, empty_out,
               almost_full_out, count_out, ovf_err_out, udf_err_out
    );

    modport slave (
        input  wr_valid_in, wr_data_in, rd_req_in,
        output wr_ready_out, rd_data_out, rd_valid_out, full_out, empty_out,
               almost_full_out, count_out, ovf_err_out, udf_err_out
    );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller wrapping a dual-port RAM with one-cycle synchronous read.
// Owns the wrap-bit pointers and registers all status flags from the next-state pointers.
module dp_ram_fifo_ctrl #(
    parameter int          ADDR_WIDTH   = 8,
    parameter int          DATA_WIDTH   = 32,
    parameter int unsigned AFULL_THRESH = 2**ADDR_WIDTH - 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    dp_ram_fifo_ctrl_if.slave     fifo_if,
    output logic                  ram_wr_en_out,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_out,
    output logic [DATA_WIDTH-1:0] ram_wr_data_out,
    output logic                  ram_rd_en_out,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_out,
    input  logic [DATA_WIDTH-1:0] ram_data_in
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] AFULL_CNT = PW'(AFULL_THRESH);

    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic [ADDR_WIDTH:0] count_q;
    logic                full_q, empty_q, afull_q;
    logic                full_nxt;
    logic                rd_valid_q;
    logic                ovf_q, udf_q;
    logic                push, pop;

    // Handshakes look only at registered flags, so full+push+pop rejects the
    // push and empty+push+pop rejects the pop (no bypass path).
    always_comb begin
        push       = fifo_if.wr_valid_in & ~full_q  & ~rst_in;
        pop        = fifo_if.rd_req_in   & ~empty_q & ~rst_in;
        wr_ptr_nxt = wr_ptr + PW'(push);
        rd_ptr_nxt = rd_ptr + PW'(pop);
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
        full_nxt   = (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            count_q    <= count_nxt;
            empty_q    <= (wr_ptr_nxt == rd_ptr_nxt);
            full_q     <= full_nxt;
            afull_q    <= (count_nxt >= AFULL_CNT);
            rd_valid_q <= pop;
            if (fifo_if.wr_valid_in && full_q) ovf_q <= 1'b1;
            if (fifo_if.rd_req_in && empty_q)  udf_q <= 1'b1;
        end
    end

    assign ram_wr_en_out   = push;
    assign ram_wr_addr_out = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data_out = fifo_if.wr_data_in;
    assign ram_rd_en_out   = pop;
    assign ram_rd_addr_out = rd_ptr[ADDR_WIDTH-1:0];

    assign fifo_if.wr_ready_out    = ~full_q;
    assign fifo_if.rd_data_out     = ram_data_in;
    assign fifo_if.rd_valid_out    = rd_valid_q;
    assign fifo_if.full_out        = full_q;
    assign fifo_if.empty_out       = empty_q;
    assign fifo_if.almost_full_out = afull_q;
    assign fifo_if.count_out       = count_q;
    assign fifo_if.ovf_err_out     = ovf_q;
    assign fifo_if.udf_err_out     = udf_q;
endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Bench for dp_ram_fifo_ctrl: queue-based occupancy model checked every cycle,
// plus directed scenarios with literal expectations; a simple RAM closes the loop.
module tb_dp_ram_fifo_ctrl;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dp_ram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fif ();

    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data, ram_rdata;
    logic [DW-1:0] mem [DEPTH];

    dp_ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .fifo_if         (fif.slave),
        .ram_wr_en_out   (ram_wr_en),
        .ram_wr_addr_out (ram_wr_addr),
        .ram_wr_data_out (ram_wr_data),
        .ram_rd_en_out   (ram_rd_en),
        .ram_rd_addr_out (ram_rd_addr),
        .ram_data_in     (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rdata <= mem[ram_rd_addr];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    // Model: a queue of stored words plus the RAM slot counters and sticky errors.
    logic [DW-1:0] q[$];
    int unsigned   m_wa, m_ra;
    bit            m_ovf, m_udf, m_pv, m_live;
    logic [DW-1:0] m_pd;
    bit            u_full, u_empty, u_push, u_pop;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_wa = 0; m_ra = 0; m_ovf = 0; m_udf = 0; m_pv = 0; m_live = 1;
        end else if (m_live) begin
            u_full  = (q.size() == DEPTH);
            u_empty = (q.size() == 0);
            u_push  = fif.wr_valid_in && !u_full;
            u_pop   = fif.rd_req_in && !u_empty;
            if (fif.wr_valid_in && u_full) m_ovf = 1;
            if (fif.rd_req_in && u_empty)  m_udf = 1;
            m_pv = u_pop;
            if (u_pop) begin
                m_pd = q.pop_front();
                m_ra = (m_ra + 1) % DEPTH;
            end
            if (u_push) begin
                q.push_back(fif.wr_data_in);
                m_wa = (m_wa + 1) % DEPTH;
            end
        end
    end

    int unsigned c_sz;
    bit          c_push, c_pop;

    always @(negedge clk) begin
        if (m_live) begin
            c_sz   = q.size();
            c_push = fif.wr_valid_in && (c_sz != DEPTH) && !rst;
            c_pop  = fif.rd_req_in && (c_sz != 0) && !rst;
            chk("count",    64'(fif.count_out),       64'(c_sz));
            chk("empty",    64'(fif.empty_out),       64'(c_sz == 0));
            chk("full",     64'(fif.full_out),        64'(c_sz == DEPTH));
            chk("afull",    64'(fif.almost_full_out), 64'(c_sz >= DEPTH - 4));
            chk("wr_ready", 64'(fif.wr_ready_out),    64'(c_sz != DEPTH));
            chk("ovf",      64'(fif.ovf_err_out),     64'(m_ovf));
            chk("udf",      64'(fif.udf_err_out),     64'(m_udf));
            chk("ram_wr_en", 64'(ram_wr_en),          64'(c_push));
            chk("ram_rd_en", 64'(ram_rd_en),          64'(c_pop));
            if (c_push) begin
                chk("ram_wr_addr", 64'(ram_wr_addr), 64'(m_wa));
                chk("ram_wr_data", 64'(ram_wr_data), 64'(fif.wr_data_in));
            end
            if (c_pop) chk("ram_rd_addr", 64'(ram_rd_addr), 64'(m_ra));
            chk("rd_valid", 64'(fif.rd_valid_out), 64'(m_pv));
            if (m_pv) chk("rd_data", 64'(fif.rd_data_out), 64'(m_pd));
        end
    end

    task automatic drive(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit rs);
        fif.wr_valid_in = wv;
        fif.wr_data_in  = wd;
        fif.rd_req_in   = rr;
        rst             = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, '0, 0, 1);
        tick(); tick();
        drive(0, '0, 0, 0);
        tick();
        chk("lit_reset_empty", 64'(fif.empty_out), 64'd1);
        chk("lit_reset_full",  64'(fif.full_out),  64'd0);
        chk("lit_reset_count", 64'(fif.count_out), 64'd0);
        chk("lit_reset_ready", 64'(fif.wr_ready_out), 64'd1);
        chk("lit_reset_wen",   64'(ram_wr_en), 64'd0);
        chk("lit_reset_ren",   64'(ram_rd_en), 64'd0);

        // Single push then pop.
        drive(1, 32'hA5, 0, 0);
        #1;
        chk("lit_push_wen",  64'(ram_wr_en),   64'd1);
        chk("lit_push_addr", 64'(ram_wr_addr), 64'd0);
        chk("lit_push_data", 64'(ram_wr_data), 64'hA5);
        tick();
        chk("lit_push_count", 64'(fif.count_out), 64'd1);
        drive(0, '0, 1, 0);
        #1;
        chk("lit_pop_ren",  64'(ram_rd_en),   64'd1);
        chk("lit_pop_addr", 64'(ram_rd_addr), 64'd0);
        tick();
        chk("lit_pop_valid", 64'(fif.rd_valid_out), 64'd1);
        chk("lit_pop_data",  64'(fif.rd_data_out),  64'hA5);
        chk("lit_pop_empty", 64'(fif.empty_out),    64'd1);
        drive(0, '0, 0, 0);
        tick();

        // Fill to full.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'(i), 0, 0);
            tick();
            if (i == 250) chk("lit_afull_251", 64'(fif.almost_full_out), 64'd0);
            if (i == 251) chk("lit_afull_252", 64'(fif.almost_full_out), 64'd1);
        end
        chk("lit_full",       64'(fif.full_out),     64'd1);
        chk("lit_full_ready", 64'(fif.wr_ready_out), 64'd0);
        chk("lit_full_count", 64'(fif.count_out),    64'd256);
        drive(1, 32'd999, 0, 0);
        #1;
        chk("lit_ovf_wen", 64'(ram_wr_en), 64'd0);
        tick();
        chk("lit_ovf_flag",  64'(fif.ovf_err_out), 64'd1);
        chk("lit_ovf_count", 64'(fif.count_out),   64'd256);

        // Full with push+pop: pop wins, push rejected.
        drive(1, 32'd1234, 1, 0);
        #1;
        chk("lit_fpp_ready", 64'(fif.wr_ready_out), 64'd0);
        chk("lit_fpp_ren",   64'(ram_rd_en), 64'd1);
        chk("lit_fpp_wen",   64'(ram_wr_en), 64'd0);
        tick();
        chk("lit_fpp_count", 64'(fif.count_out),   64'd255);
        chk("lit_fpp_valid", 64'(fif.rd_valid_out), 64'd1);
        chk("lit_fpp_data",  64'(fif.rd_data_out),  64'd0);
        for (int i = 1; i < DEPTH; i++) begin
            drive(0, '0, 1, 0);
            tick();
            chk("lit_drain_data", 64'(fif.rd_data_out), 64'(i));
        end
        drive(0, '0, 0, 0);
        tick();
        chk("lit_drain_empty", 64'(fif.empty_out), 64'd1);

        // Wrap: stay at occupancy 1 while pointers cross the RAM boundary.
        drive(1, 32'd5000, 0, 0);
        tick();
        for (int k = 0; k < 300; k++) begin
            drive(1, 32'(6000 + k), 1, 0);
            tick();
            chk("lit_wrap_count", 64'(fif.count_out), 64'd1);
            chk("lit_wrap_data",  64'(fif.rd_data_out), (k == 0) ? 64'd5000 : 64'(6000 + k - 1));
        end
        drive(0, '0, 1, 0);
        tick();
        chk("lit_wrap_last",  64'(fif.rd_data_out), 64'd6299);
        chk("lit_wrap_empty", 64'(fif.empty_out),   64'd1);
        chk("lit_wrap_udf",   64'(fif.udf_err_out), 64'd0);

        // Empty with push+pop: push wins, no bypass.
        drive(1, 32'd77, 1, 0);
        tick();
        chk("lit_epp_count", 64'(fif.count_out),    64'd1);
        chk("lit_epp_valid", 64'(fif.rd_valid_out), 64'd0);
        chk("lit_epp_udf",   64'(fif.udf_err_out),  64'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(80 + i), 0, 0);
            tick();
        end
        chk("lit_five", 64'(fif.count_out), 64'd5);
        drive(1, 32'd88, 1, 0);
        tick();
        chk("lit_pre_rst_count", 64'(fif.count_out), 64'd5);

        // Reset mid-stream with requests still asserted.
        drive(1, 32'd99, 1, 1);
        #1;
        chk("lit_rst_wen", 64'(ram_wr_en), 64'd0);
        chk("lit_rst_ren", 64'(ram_rd_en), 64'd0);
        tick();
        chk("lit_rst_count", 64'(fif.count_out),    64'd0);
        chk("lit_rst_empty", 64'(fif.empty_out),    64'd1);
        chk("lit_rst_ovf",   64'(fif.ovf_err_out),  64'd0);
        chk("lit_rst_udf",   64'(fif.udf_err_out),  64'd0);
        chk("lit_rst_valid", 64'(fif.rd_valid_out), 64'd0);
        drive(0, '0, 0, 0);
        tick();
        chk("lit_post_rst_valid", 64'(fif.rd_valid_out), 64'd0);

        // Fresh traffic after reset restarts at address 0.
        drive(1, 32'h55, 0, 0);
        #1;
        chk("lit_again_addr", 64'(ram_wr_addr), 64'd0);
        tick();
        drive(0, '0, 1, 0);
        tick();
        chk("lit_again_data", 64'(fif.rd_data_out), 64'h55);
        drive(0, '0, 0, 0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dp_ram_fifo_ctrl.md
Name: dp_ram_fifo_ctrl

Overview:
- Synchronous FIFO controller sitting directly upstream of the dual-port RAM (dp_ram_rtl); owns write/read pointers and drives the RAM's wr_en/wr_addr/data_in and rd_en/rd_addr ports.
- Presents a valid/ready push interface to the producer and a request/valid pop interface to the consumer, turning the raw RAM into a 2^ADDR_WIDTH-deep FIFO with full/empty/count status.
- RAM read is synchronous, one-cycle latency: data_out is valid the cycle after rd_en is sampled high.

Parameters:
- ADDR_WIDTH, 8, RAM address width; FIFO depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 32, data word width.
- AFULL_THRESH, 2^ADDR_WIDTH-4, almost_full asserts when count >= this value.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  synchronous reset, active-high.
- wr_valid_in  input  1  producer offers wr_data_in.
- wr_data_in  input  DATA_WIDTH  push data.
- wr_ready_out  output  1  controller can accept a push (= !full).
- rd_req_in  input  1  consumer requests one word.
- rd_data_out  output  DATA_WIDTH  popped data (pass-through of ram_data_in).
- rd_valid_out  output  1  rd_data_out valid this cycle.
- full_out  output  1  count == 2^ADDR_WIDTH.
- empty_out  output  1  count == 0.
- almost_full_out  output  1  count >= AFULL_THRESH.
- count_out  output  ADDR_WIDTH+1  current occupancy.
- ovf_err_out  output  1  sticky: push attempted while full.
- udf_err_out  output  1  sticky: pop requested while empty.
- ram_wr_en_out  output  1  to RAM wr_en.
- ram_wr_addr_out  output  ADDR_WIDTH  to RAM wr_addr.
- ram_wr_data_out  output  DATA_WIDTH  to RAM data_in.
- ram_rd_en_out  output  1  to RAM rd_en.
- ram_rd_addr_out  output  ADDR_WIDTH  to RAM rd_addr.
- ram_data_in  input  DATA_WIDTH  from RAM data_out.

Behaviour:
- Pointers wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address the RAM, and the MSB is the wrap bit. They wrap naturally from 2^(ADDR_WIDTH+1)-1 to 0.
- Flags and count are registered: empty = (wr_ptr == rd_ptr); full = (low bits equal, MSBs differ); count = wr_ptr - rd_ptr.
- push = wr_valid_in & !full_out; pop = rd_req_in & !empty_out. Both are evaluated against the registered flags of the current cycle.
- RAM-side outputs are combinational from the handshakes:
  - ram_wr_en_out = push; ram_wr_addr_out = wr_ptr low bits; ram_wr_data_out = wr_data_in.
  - ram_rd_en_out = pop; ram_rd_addr_out = rd_ptr low bits.
- Pointer updates on the clock edge: push → wr_ptr+1; pop → rd_ptr+1. Simultaneous push and pop both execute and count is unchanged.
- rd_valid_out is the registered version of pop, so it asserts in the cycle after the request is accepted. rd_data_out = ram_data_in. Read latency is exactly 1 cycle, and back-to-back pops stream one word per cycle.
- Boundary conditions:
  - Full with simultaneous push+pop: the pop executes and the push is rejected (wr_ready_out=0 that cycle), so count goes from 2^ADDR_WIDTH to 2^ADDR_WIDTH-1.
  - Empty with simultaneous push+pop: the push executes and the pop is rejected (no bypass), so count goes from 0 to 1 and rd_valid_out stays 0 next cycle.
  - Push while full: the word is dropped, nothing is written, and ovf_err_out sets to 1 and stays set until reset.
  - Pop while empty: ignored, and udf_err_out sets to 1 and stays set until reset.
  - A write never targets an occupied entry and a read never targets an unwritten entry, so no RAM read-during-write hazard exists.
- Reset (rst_in=1 at an edge):
  - wr_ptr=rd_ptr=0, count_out=0, empty_out=1, full_out=0, almost_full_out=0, rd_valid_out=0, ovf/udf_err=0.
  - While rst_in is high, ram_wr_en_out and ram_rd_en_out are forced to 0.
  - Reset mid-stream discards all contents; a read issued the cycle before reset produces no rd_valid_out after reset.

Test Plan:
- Reset then idle → empty_out=1, full_out=0, count_out=0, wr_ready_out=1, all RAM enables 0.
- Push 0xA5 → ram_wr_en_out=1, ram_wr_addr_out=0, ram_wr_data_out=0xA5, count 1. Pop next cycle → ram_rd_en_out=1, ram_rd_addr_out=0; following cycle rd_valid_out=1, rd_data_out=0xA5, empty_out=1.
- Push 256 words (values 0..255) → full_out=1, almost_full_out set from count 252, wr_ready_out=0. Push 999 → dropped, ovf_err_out=1, count stays 256.
- When full, drive push+pop together → pop returns 0, push rejected, count 255. Pop all remaining → data 1..255 in order, then empty_out=1.
- Wrap test: 300 interleaved push/pop pairs at count 1 → addresses wrap 255→0, data stays in order, count remains 1.
- When empty, drive push+pop together → count 1, no rd_valid_out, udf_err_out=1. Assert rst_in with 5 entries stored → count 0, empty_out=1, errors cleared.
